// File: rtl/mem_load_ctrl.sv
// Serial load/run sequencer for the tiny processor's icache and dcache.
// Define LOADER_CHKSUM_EN to enable the XOR checksum of committed data bytes.
module mem_load_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_in,
  input  logic              mosi_in,
  input  logic              core_halt_in,
  output logic              icache_wen_out,
  output logic              dcache_wen_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              run_out,
  output logic              done_out,
  output logic              frame_err_out,
  output logic              addr_err_out,
  output logic [DATA_W-1:0] chksum_out
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_I    = 2'b01;
  localparam logic [1:0] MODE_D    = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_I,
    SHIFT_D,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shift_buf;
  logic               wait_zero;

  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic [1:0]         shift_mode;
  logic               frame_last;
  logic               addr_ok;

  // The final bit is still on mosi_in when the frame completes, so it is
  // spliced in directly as the data MSB.
  assign frame_addr = shift_buf[ADDR_W-1:0];
  assign frame_data = {mosi_in, shift_buf[FRAME_W-2:ADDR_W]};
  assign frame_last = (bit_cnt == LAST_BIT);
  assign shift_mode = (state == SHIFT_I) ? MODE_I : MODE_D;
  assign addr_ok    = (state == SHIFT_I) ? (32'(frame_addr) < IMEM_DEPTH)
                                         : (32'(frame_addr) < DMEM_DEPTH);

`ifndef LOADER_CHKSUM_EN
  assign chksum_out = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift_buf      <= '0;
      wait_zero      <= 1'b0;
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      run_out        <= 1'b0;
      done_out       <= 1'b1;
      frame_err_out  <= 1'b0;
      addr_err_out   <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      chksum_out     <= '0;
`endif
    end else begin
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;

      case (state)
        IDLE: begin
          // After an illegal mode switch, mode 00 must be seen before re-entry.
          if (wait_zero) begin
            if (mode_in == MODE_NONE) wait_zero <= 1'b0;
          end else begin
            case (mode_in)
              MODE_I, MODE_D: begin
                state        <= (mode_in == MODE_I) ? SHIFT_I : SHIFT_D;
                shift_buf[0] <= mosi_in;
                bit_cnt      <= CNT_W'(1);
                done_out     <= 1'b0;
`ifdef LOADER_CHKSUM_EN
                chksum_out   <= '0;
`endif
              end
              MODE_RUN: begin
                state         <= RUN;
                run_out       <= 1'b1;
                done_out      <= 1'b0;
                frame_err_out <= 1'b0;
                addr_err_out  <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        SHIFT_I, SHIFT_D: begin
          if (mode_in == shift_mode) begin
            shift_buf[bit_cnt] <= mosi_in;
            if (frame_last) begin
              bit_cnt     <= '0;
              wr_addr_out <= frame_addr;
              wr_data_out <= frame_data;
              if (addr_ok) begin
                icache_wen_out <= (state == SHIFT_I);
                dcache_wen_out <= (state == SHIFT_D);
`ifdef LOADER_CHKSUM_EN
                chksum_out     <= chksum_out ^ frame_data;
`endif
              end else begin
                addr_err_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            state    <= IDLE;
            done_out <= 1'b1;
            bit_cnt  <= '0;
            if (mode_in != MODE_NONE) begin
              frame_err_out <= 1'b1;
              wait_zero     <= 1'b1;
            end else if (bit_cnt != '0) begin
              frame_err_out <= 1'b1;
            end
          end
        end

        RUN: begin
          // Leaving mode 11 aborts the run without flagging an error.
          if (mode_in != MODE_RUN) begin
            state     <= IDLE;
            run_out   <= 1'b0;
            done_out  <= 1'b1;
            wait_zero <= (mode_in != MODE_NONE);
          end else if (core_halt_in) begin
            state    <= DONE;
            run_out  <= 1'b0;
            done_out <= 1'b1;
          end
        end

        DONE: begin
          if (mode_in == MODE_NONE) state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          run_out  <= 1'b0;
          done_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Scoreboard bench for mem_load_ctrl: expected writes are queued as frames are
// shifted in and popped by a monitor whenever a write strobe appears.
module tb_mem_load_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] mode_in;
  logic       mosi_in;
  logic       core_halt_in;
  logic       icache_wen_out;
  logic       dcache_wen_out;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic       run_out;
  logic       done_out;
  logic       frame_err_out;
  logic       addr_err_out;
  logic [7:0] chksum_out;

  typedef struct {
    logic       icache;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wen_cycles[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  mem_load_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mode_in        (mode_in),
    .mosi_in        (mosi_in),
    .core_halt_in   (core_halt_in),
    .icache_wen_out (icache_wen_out),
    .dcache_wen_out (dcache_wen_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .run_out        (run_out),
    .done_out       (done_out),
    .frame_err_out  (frame_err_out),
    .addr_err_out   (addr_err_out),
    .chksum_out     (chksum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the oldest queued write and never overlap.
  always @(negedge clk) begin
    if (!rst && (icache_wen_out || dcache_wen_out)) begin
      wr_t e;
      wen_cycles.push_back(cyc);
      compared++;
      if (icache_wen_out && dcache_wen_out) begin
        mismatched++;
        $display("[TB] FAIL wen_exclusive: both strobes high at cycle %0d", cyc);
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_wen: ic=%0b dc=%0b addr=%h data=%h, none expected",
                 icache_wen_out, dcache_wen_out, wr_addr_out, wr_data_out);
      end else begin
        e = exp_q.pop_front();
        if ({icache_wen_out, wr_addr_out, wr_data_out} !== {e.icache, e.addr, e.data}) begin
          mismatched++;
          $display("[TB] FAIL wen_record: got ic=%0b addr=%h data=%h, want ic=%0b addr=%h data=%h",
                   icache_wen_out, wr_addr_out, wr_data_out, e.icache, e.addr, e.data);
        end
      end
    end
  end

  task automatic shift_bits(input logic [11:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi_in = frame[i];
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mode_in = 2'b00; mosi_in = 1'b0; core_halt_in = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({icache_wen_out, dcache_wen_out, run_out, done_out, frame_err_out, addr_err_out} !== 6'b000100) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b want 000100",
               {icache_wen_out, dcache_wen_out, run_out, done_out, frame_err_out, addr_err_out});
    end
    compared++;
    if ({wr_addr_out, wr_data_out, chksum_out} !== 20'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got %h want 00000", {wr_addr_out, wr_data_out, chksum_out});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_icache;
    mode_in = 2'b01;
    exp_q.push_back(wr_t'{1'b1, 4'h3, 8'hA5});
    shift_bits({8'hA5, 4'h3}, 12);
    compared++;
    if (icache_wen_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL icache_latency: wen=%0b one cycle after bit 11, want 1", icache_wen_out);
    end
    mode_in = 2'b00;
    @(negedge clk);
    compared++;
    if ({icache_wen_out, frame_err_out, addr_err_out, done_out} !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL icache_after: wen/ferr/aerr/done=%b want 0001",
               {icache_wen_out, frame_err_out, addr_err_out, done_out});
    end
    // Top icache address is still in range.
    mode_in = 2'b01;
    exp_q.push_back(wr_t'{1'b1, 4'hF, 8'h5A});
    shift_bits({8'h5A, 4'hF}, 12);
    mode_in = 2'b00;
    @(negedge clk);
    compared++;
    if (addr_err_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL icache_top_addr: addr_err=%0b want 0", addr_err_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_sum;
    wen_cycles.delete();
    mode_in = 2'b10;
    exp_q.push_back(wr_t'{1'b0, 4'h0, 8'h11});
    exp_q.push_back(wr_t'{1'b0, 4'hC, 8'h22});
    shift_bits({8'h11, 4'h0}, 12);
    shift_bits({8'h22, 4'hC}, 12);
    mode_in = 2'b00;
    @(negedge clk);
    compared++;
    if (wen_cycles.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL b2b_count: %0d strobes, want 2", wen_cycles.size());
    end else if (wen_cycles[1] - wen_cycles[0] != 12) begin
      mismatched++;
      $display("[TB] FAIL b2b_spacing: %0d cycles apart, want 12", wen_cycles[1] - wen_cycles[0]);
    end
`ifdef LOADER_CHKSUM_EN
    exp_sum = 8'h11 ^ 8'h22;
`else
    exp_sum = 8'h00;
`endif
    compared++;
    if (chksum_out !== exp_sum) begin
      mismatched++;
      $display("[TB] FAIL b2b_chksum: got %h want %h", chksum_out, exp_sum);
    end
  endtask

  task automatic test_addr_range;
    mode_in = 2'b10;
    shift_bits({8'hFF, 4'hD}, 12);
    mode_in = 2'b00;
    @(negedge clk);
    compared++;
    if ({addr_err_out, frame_err_out} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL range_flags: aerr/ferr=%b want 10", {addr_err_out, frame_err_out});
    end
    compared++;
    if ({wr_addr_out, wr_data_out, chksum_out} !== {4'hD, 8'hFF, 8'h00}) begin
      mismatched++;
      $display("[TB] FAIL range_commit: addr/data/sum=%h want dff00", {wr_addr_out, wr_data_out, chksum_out});
    end
  endtask

  task automatic test_partial;
    mode_in = 2'b01;
    shift_bits(12'hB6D, 7);
    mode_in = 2'b00;
    @(negedge clk);
    compared++;
    if ({frame_err_out, done_out} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL partial_flags: ferr/done=%b want 11", {frame_err_out, done_out});
    end
    mode_in = 2'b11;
    @(negedge clk);
    compared++;
    if ({frame_err_out, addr_err_out, run_out} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL run_clears_err: ferr/aerr/run=%b want 001", {frame_err_out, addr_err_out, run_out});
    end
    mode_in = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_run;
    int high_cycles;
    high_cycles = 0;
    mode_in = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (run_out === 1'b1) high_cycles++;
    end
    compared++;
    if (high_cycles != 20) begin
      mismatched++;
      $display("[TB] FAIL run_high: run high %0d cycles, want 20", high_cycles);
    end
    core_halt_in = 1'b1;
    @(negedge clk);
    compared++;
    if ({run_out, done_out} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL halt_done: run/done=%b want 01", {run_out, done_out});
    end
    core_halt_in = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({run_out, done_out} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL done_holds: run/done=%b want 01", {run_out, done_out});
    end
    mode_in = 2'b00;
    @(negedge clk);
    mode_in = 2'b11;
    @(negedge clk);
    compared++;
    if ({run_out, done_out} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL rerun_from_idle: run/done=%b want 10", {run_out, done_out});
    end
    mode_in = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_direct_switch;
    mode_in = 2'b01;
    shift_bits(12'h5A5, 3);
    mode_in = 2'b10;
    @(negedge clk);
    compared++;
    if ({frame_err_out, done_out} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL switch_err: ferr/done=%b want 11", {frame_err_out, done_out});
    end
    shift_bits({8'h77, 4'h1}, 12);
    compared++;
    if (done_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL switch_blocked: done=%0b want 1", done_out);
    end
    mode_in = 2'b00;
    @(negedge clk);
    mode_in = 2'b10;
    exp_q.push_back(wr_t'{1'b0, 4'h2, 8'h3C});
    shift_bits({8'h3C, 4'h2}, 12);
    compared++;
    if (dcache_wen_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL switch_recover: dcache_wen=%0b want 1", dcache_wen_out);
    end
    mode_in = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [11:0] frame;
    frame = {8'hC3, 4'h6};
    mode_in = 2'b01;
    shift_bits(frame, 5);
    mosi_in = frame[5];
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({icache_wen_out, dcache_wen_out, run_out, done_out, frame_err_out, addr_err_out,
         wr_addr_out, wr_data_out, chksum_out} !== {6'b000100, 20'h0}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: flags=%b data=%h want 000100/00000",
               {icache_wen_out, dcache_wen_out, run_out, done_out, frame_err_out, addr_err_out},
               {wr_addr_out, wr_data_out, chksum_out});
    end
    @(negedge clk);
    mode_in = 2'b00;
    rst = 1'b0;
    shift_bits(frame, 12);
    compared++;
    if (done_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: done=%0b want 1", done_out);
    end
  endtask

  initial begin
    test_reset();
    test_icache();
    test_back_to_back();
    test_addr_range();
    test_partial();
    test_run();
    test_direct_switch();
    test_reset_midframe();
    repeat (2) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL missing_wen: %0d expected writes never seen", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
- Serial load and run sequencer for the tiny processor's instruction and data caches.
- Deserialises 12-bit frames (4-bit address + 8-bit data) from the master's chip-select/MOSI pins and issues single-cycle write strobes to the icache or dcache.
- Detects malformed and out-of-range frames.
- Gates the processor's execute phase, and reports completion back to the master.

Parameters:
- DATA_W, 8, cache data width
- ADDR_W, 4, cache address width
- IMEM_DEPTH, 16, valid icache entries (addresses 0..IMEM_DEPTH-1)
- DMEM_DEPTH, 13, valid dcache entries (addresses 0..DMEM_DEPTH-1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mode_in  in  2  master mode: 00 none, 01 icache select, 10 dcache select, 11 run
- mosi_in  in  1  serial data, sampled every clk while a select mode is held
- core_halt_in  in  1  core signals last instruction retired (pc frozen)
- icache_wen_out  out  1  icache write strobe
- dcache_wen_out  out  1  dcache write strobe
- wr_addr_out  out  ADDR_W  write address, valid while a wen is high
- wr_data_out  out  DATA_W  write data, valid while a wen is high
- run_out  out  1  core execute enable (core pc held in reset when 0)
- done_out  out  1  high in IDLE and DONE; low while loading or running
- frame_err_out  out  1  sticky: partial frame or illegal mode change
- addr_err_out  out  1  sticky: frame addressed beyond depth
- chksum_out  out  DATA_W  running checksum (see Optional Feature)

Behaviour:
- Reset (async): state IDLE, bit counter 0, shift buffer 0.
  - All wen outputs, run_out, the err flags and chksum_out are 0.
  - wr_addr_out and wr_data_out are 0; done_out is 1.
- States: IDLE, SHIFT_I, SHIFT_D, RUN, DONE.
- From IDLE:
  - mode 01 goes to SHIFT_I; 10 goes to SHIFT_D; 11 goes to RUN; 00 stays in IDLE.
  - The bit captured on the entry edge is bit 0 of the first frame.
- SHIFT_x, per cycle:
  - Each cycle captures mosi_in into a 12-bit buffer, LSB-first.
  - Frame bits 0-3 are the address and bits 4-11 are the data.
  - A 4-bit counter counts 0..11.
- Frame completion:
  - The edge capturing bit 11 latches addr and data into the commit registers and wraps the counter to 0.
  - The matching wen is asserted on the next cycle, for exactly 1 cycle (latency: 1 cycle after the last bit).
  - Frames may be sent back-to-back with no gap; capture of the next frame overlaps the wen cycle.
- Range check:
  - Address >= IMEM_DEPTH (SHIFT_I) or >= DMEM_DEPTH (SHIFT_D): no wen is issued and addr_err_out is set.
  - The commit registers still update.
- Deselect (mode returns to 00):
  - With counter == 0: go to IDLE cleanly.
  - With counter != 0: discard the partial frame, set frame_err_out, go to IDLE.
- Direct switch between modes 01, 10 and 11 without passing 00: discard any partial frame, set frame_err_out, go to IDLE. No new mode is entered until 00 has been seen for at least 1 cycle.
- RUN:
  - run_out = 1 while mode_in == 11 and core_halt_in == 0.
  - core_halt_in = 1 goes to DONE, with run_out dropping on the same edge.
  - mode leaving 11 before the halt goes to IDLE (run aborted, no error).
- DONE: run_out = 0, done_out = 1; stays until mode_in == 00, then goes to IDLE.
- Error flags:
  - Cleared only by reset or on entry to RUN.
  - Never cleared by a new load.
- wen exclusivity: icache_wen_out and dcache_wen_out are never both 1.

Optional Feature:
- Macro: LOADER_CHKSUM_EN.
- When defined:
  - chksum_out is an 8-bit XOR of the data byte of every committed, in-range frame.
  - It is cleared on entry to SHIFT_I or SHIFT_D.
  - It is held in all other states.
- When undefined: chksum_out is tied to 0 and no checksum register exists.

Test Plan:
- Mode 01, shift frame addr=0x3 data=0xA5 (12 bits LSB-first), then mode 00:
  - icache_wen_out pulses 1 cycle, 1 cycle after bit 11, with wr_addr=0x3 and wr_data=0xA5.
  - No errors are flagged.
- Mode 10, two back-to-back frames (0x0/0x11, 0xC/0x22):
  - Two dcache_wen_out pulses exactly 12 cycles apart.
  - With LOADER_CHKSUM_EN, chksum_out = 0x33.
- Mode 10, frame addr=0xD data=0xFF: no dcache_wen_out pulse, addr_err_out = 1.
- Mode 01, shift 7 bits, then mode 00: no wen, frame_err_out = 1, done_out = 1. Entering mode 11 clears frame_err_out.
- Mode 11, assert core_halt_in after 20 cycles:
  - run_out is high for those 20 cycles, then 0.
  - State is DONE with done_out = 1; it returns to IDLE only after mode 00.
- Assert rst mid-frame (bit 5 of a mode-01 frame): all outputs clear asynchronously, and no wen is issued after release.
